// File: rtl/spi_pkg.sv
// Shared constants for the two-requester SPI master: default frame length
// and the serialiser state encoding.
package spi_pkg;

  localparam int SPI_DATA_LENGTH = 8;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOW  = 3'd1;
  localparam logic [2:0] ST_HIGH = 3'd2;
  localparam logic [2:0] ST_HOLD = 3'd3;
  localparam logic [2:0] ST_GAP  = 3'd4;

endpackage

// File: rtl/m_spi_shift.sv
// SPI frame serialiser: SCLK divider, bit counter, tx/rx shift registers and
// SS/SCLK/MOSI generation for one MSB-first frame per start strobe.
module m_spi_shift
  import spi_pkg::*;
#(
  parameter int DATA_LENGTH = SPI_DATA_LENGTH,
  parameter int CLK_DIV     = 4,
  parameter int SS_GAP      = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [DATA_LENGTH-1:0] tx_data,
  input  logic                   miso,
  output logic                   ready,
  output logic                   done,
  output logic                   gap_end,
  output logic [DATA_LENGTH-1:0] rx_data,
  output logic                   sclk,
  output logic                   ss,
  output logic                   mosi,
  output logic [2:0]             state
);

  // Handshake: start is taken only while ready (IDLE) and loads tx_data on
  // that edge; done pulses on the edge SS rises with rx_data complete;
  // gap_end pulses on the edge the serialiser returns to IDLE.
  localparam int CW = $clog2(SS_GAP * CLK_DIV) + 1;
  localparam int BW = $clog2(DATA_LENGTH) + 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(SS_GAP * CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_LENGTH - 1);

  logic [2:0]             state_q, state_d;
  logic [CW-1:0]          div_q, div_d;
  logic [BW-1:0]          bit_q, bit_d;
  logic [DATA_LENGTH-1:0] tx_q, tx_d;
  logic [DATA_LENGTH-1:0] rx_q, rx_d;
  logic                   sclk_q, sclk_d;
  logic                   ss_q, ss_d;
  logic                   mosi_q, mosi_d;
  logic                   half_done;

  assign half_done = (div_q == HALF_LAST);

  always_comb begin
    state_d = state_q;
    div_d   = div_q + CW'(1);
    bit_d   = bit_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    sclk_d  = sclk_q;
    ss_d    = ss_q;
    mosi_d  = mosi_q;
    done    = 1'b0;
    gap_end = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        div_d = '0;
        if (start) begin
          state_d = ST_LOW;
          tx_d    = tx_data;
          rx_d    = '0;
          bit_d   = '0;
          ss_d    = 1'b0;
          mosi_d  = tx_data[DATA_LENGTH-1];
        end
      end
      ST_LOW: begin
        if (half_done) begin
          state_d = ST_HIGH;
          div_d   = '0;
          sclk_d  = 1'b1;
          rx_d    = {rx_q[DATA_LENGTH-2:0], miso};
        end
      end
      ST_HIGH: begin
        if (half_done) begin
          div_d  = '0;
          sclk_d = 1'b0;
          bit_d  = bit_q + BW'(1);
          // After the last bit MOSI keeps its value through HOLD.
          if (bit_q == BIT_LAST) begin
            state_d = ST_HOLD;
          end else begin
            state_d = ST_LOW;
            tx_d    = tx_q << 1;
            mosi_d  = tx_q[DATA_LENGTH-2];
          end
        end
      end
      ST_HOLD: begin
        if (half_done) begin
          state_d = ST_GAP;
          div_d   = '0;
          ss_d    = 1'b1;
          mosi_d  = 1'b0;
          done    = 1'b1;
        end
      end
      ST_GAP: begin
        if (div_q == GAP_LAST) begin
          state_d = ST_IDLE;
          div_d   = '0;
          gap_end = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        div_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      sclk_q  <= 1'b0;
      ss_q    <= 1'b1;
      mosi_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      sclk_q  <= sclk_d;
      ss_q    <= ss_d;
      mosi_q  <= mosi_d;
    end
  end

  assign ready   = (state_q == ST_IDLE);
  assign rx_data = rx_q;
  assign sclk    = sclk_q;
  assign ss      = ss_q;
  assign mosi    = mosi_q;
  assign state   = state_q;

endmodule

// File: rtl/m_spi_arbiter.sv
// Two-requester SPI master: round-robin grant, ack/busy handshake and
// tagged read-data return around the m_spi_shift serialiser.
module m_spi_arbiter
  import spi_pkg::*;
#(
  parameter int DATA_LENGTH = SPI_DATA_LENGTH,
  parameter int CLK_DIV     = 4,
  parameter int SS_GAP      = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req0,
  input  logic                   req1,
  input  logic [DATA_LENGTH-1:0] wdata0,
  input  logic [DATA_LENGTH-1:0] wdata1,
  output logic                   ack0,
  output logic                   ack1,
  output logic [DATA_LENGTH-1:0] rdata,
  output logic                   rid,
  output logic                   rvalid,
  output logic                   busy,
  output logic                   SCLK,
  output logic                   SS,
  output logic                   MOSI,
  input  logic                   MISO,
  output logic [2:0]             dbg_state
);

  logic                   armed_q, armed_d;
  logic                   last_q, last_d;
  logic                   ack0_q, ack0_d;
  logic                   ack1_q, ack1_d;
  logic                   rid_q, rid_d;
  logic                   rvalid_q, rvalid_d;
  logic                   busy_q, busy_d;
  logic [DATA_LENGTH-1:0] rdata_q, rdata_d;

  logic                   grant;
  logic                   start;
  logic                   ready;
  logic                   done;
  logic                   gap_end;
  logic [DATA_LENGTH-1:0] tx_data;
  logic [DATA_LENGTH-1:0] rx_data;

  always_comb begin
    // On a tie the requester that did not win last time gets the bus.
    grant    = (req0 && req1) ? ~last_q : req1;
    // armed_q holds off the first grant until one edge after reset release.
    start    = ready && armed_q && (req0 || req1);
    tx_data  = grant ? wdata1 : wdata0;
    armed_d  = 1'b1;
    last_d   = start ? grant : last_q;
    ack0_d   = start && !grant;
    ack1_d   = start && grant;
    rvalid_d = done;
    rid_d    = rid_q;
    rdata_d  = rdata_q;
    if (done) begin
      rid_d   = last_q;
      rdata_d = rx_data;
    end
    busy_d = busy_q;
    if (start) begin
      busy_d = 1'b1;
    end else if (gap_end) begin
      busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      armed_q  <= 1'b0;
      last_q   <= 1'b1;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rid_q    <= 1'b0;
      rvalid_q <= 1'b0;
      busy_q   <= 1'b0;
      rdata_q  <= '0;
    end else begin
      armed_q  <= armed_d;
      last_q   <= last_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      rid_q    <= rid_d;
      rvalid_q <= rvalid_d;
      busy_q   <= busy_d;
      rdata_q  <= rdata_d;
    end
  end

  m_spi_shift #(
    .DATA_LENGTH (DATA_LENGTH),
    .CLK_DIV     (CLK_DIV),
    .SS_GAP      (SS_GAP)
  ) u_shift (
    .clk     (clk),
    .rst_n   (reset),
    .start   (start),
    .tx_data (tx_data),
    .miso    (MISO),
    .ready   (ready),
    .done    (done),
    .gap_end (gap_end),
    .rx_data (rx_data),
    .sclk    (SCLK),
    .ss      (SS),
    .mosi    (MOSI),
    .state   (dbg_state)
  );

  assign ack0   = ack0_q;
  assign ack1   = ack1_q;
  assign rid    = rid_q;
  assign rvalid = rvalid_q;
  assign busy   = busy_q;
  assign rdata  = rdata_q;

endmodule
